// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: A - B - Bin, one bit per clock, LSB first.
// Diff/Bout are registered and only change when an operation completes.
module serial_subtractor #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic [W-1:0] A,
   input  logic [W-1:0] B,
   input  logic         Bin,
   output logic         busy,
   output logic         done,
   output logic [W-1:0] Diff,
   output logic         Bout
);

   localparam int CW = $clog2(W);

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

   state_t        state;
   state_t        state_nx;
   logic [W-1:0]  a_sr;
   logic [W-1:0]  b_sr;
   logic [W-1:0]  res;
   logic [W-1:0]  res_nx;
   logic [CW-1:0] cnt;
   logic          br;
   logic          br_nx;
   logic          d;
   logic          last;

   assign d      = a_sr[0] ^ b_sr[0] ^ br;
   assign br_nx  = (~a_sr[0] & b_sr[0])
                 | (~(a_sr[0] ^ b_sr[0]) & br);
   assign res_nx = {d, res[W-1:1]};
   assign last   = (cnt == CW'(W - 1));

   assign busy = (state != IDLE);
   assign done = (state == DONE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE:    if (start) state_nx = RUN;
         RUN:     if (last) state_nx = DONE;
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_sr <= '0;
         b_sr <= '0;
         res  <= '0;
         br   <= 1'b0;
         cnt  <= '0;
         Diff <= '0;
         Bout <= 1'b0;
      end else if (state == IDLE && start) begin
         a_sr <= A;
         b_sr <= B;
         br   <= Bin;
         res  <= '0;
         cnt  <= '0;
      end else if (state == RUN) begin
         a_sr <= a_sr >> 1;
         b_sr <= b_sr >> 1;
         res  <= res_nx;
         br   <= br_nx;
         cnt  <= cnt + CW'(1);
         // final bit goes straight to the outputs on the way into DONE
         if (last) begin
            Diff <= res_nx;
            Bout <= br_nx;
         end
      end
   end

endmodule

// File: tb/tb_serial_subtractor.sv
// Randomized bench for serial_subtractor with a cycle-level arithmetic
// model plus directed literal cases and an asynchronous-abort case.
module tb_serial_subtractor;

   localparam int W    = 8;
   localparam int NOPS = 4000;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         start;
   logic [W-1:0] A;
   logic [W-1:0] B;
   logic         Bin;
   logic         busy;
   logic         done;
   logic [W-1:0] Diff;
   logic         Bout;

   int checks = 0;
   int errors = 0;
   int dut_dn = 0;

   logic         m_act;
   int           m_age;
   logic [W-1:0] m_a;
   logic [W-1:0] m_b;
   logic         m_bin;
   logic [W-1:0] m_diff;
   logic         m_bout;
   int           m_dn;

   serial_subtractor #(.W(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .A     (A),
      .B     (B),
      .Bin   (Bin),
      .busy  (busy),
      .done  (done),
      .Diff  (Diff),
      .Bout  (Bout)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm,
                      input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s t=%0t got %0h exp %0h",
                  nm, $time, got, exp);
      end
   endtask

   // Model: an accepted op occupies W+1 cycles; result lands W edges later.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_act  <= 1'b0;
         m_age  <= 0;
         m_diff <= '0;
         m_bout <= 1'b0;
      end else if (m_act) begin
         m_age <= m_age + 1;
         if (m_age == W - 1) begin
            m_diff <= m_a - m_b - W'(m_bin);
            m_bout <= ({1'b0, m_a} < ({1'b0, m_b} + (W+1)'(m_bin)));
            m_dn   <= m_dn + 1;
         end
         if (m_age == W) m_act <= 1'b0;
      end else if (start) begin
         m_act <= 1'b1;
         m_age <= 0;
         m_a   <= A;
         m_b   <= B;
         m_bin <= Bin;
      end
   end

   always @(negedge clk) begin
      if (rst_n) begin
         chk("busy", 32'(busy), 32'(m_act));
         chk("done", 32'(done), 32'(m_act && m_age == W));
         chk("diff", 32'(Diff), 32'(m_diff));
         chk("bout", 32'(Bout), 32'(m_bout));
         if (done) dut_dn++;
      end
   end

   task automatic wait_done(output int n);
      n = 1;
      while (!done && n < 40) begin
         @(posedge clk);
         #1;
         n++;
      end
   endtask

   task automatic run_op(input logic [W-1:0] a,
                         input logic [W-1:0] b,
                         input logic bin,
                         input logic [W-1:0] ed,
                         input logic eb);
      int n;
      int bc;
      @(posedge clk);
      #1;
      A = a;
      B = b;
      Bin = bin;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      A = 8'($urandom);
      B = 8'($urandom);
      n = 1;
      bc = 0;
      forever begin
         if (busy) bc++;
         if (done || n >= 40) break;
         @(posedge clk);
         #1;
         n++;
      end
      chk("op_latency", 32'(n), 32'(W + 1));
      chk("op_busy_cycles", 32'(bc), 32'(W + 1));
      chk("op_diff", 32'(Diff), 32'(ed));
      chk("op_bout", 32'(Bout), 32'(eb));
   endtask

   initial begin
      #1_500_000;
      $display("FAIL watchdog t=%0t", $time);
      $fatal(1);
   end

   initial begin
      int n;
      int dn;
      int k;
      m_dn  = 0;
      rst_n = 1'b0;
      start = 1'b1;
      A     = 8'h44;
      B     = 8'h04;
      Bin   = 1'b0;
      #3;
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_diff", 32'(Diff), 32'd0);
      chk("rst_bout", 32'(Bout), 32'd0);
      #9;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      chk("first_edge_accept", 32'(busy), 32'd1);
      wait_done(n);
      chk("first_latency", 32'(n), 32'(W + 1));
      chk("first_diff", 32'(Diff), 32'h40);

      run_op(8'h5A, 8'h3C, 1'b0, 8'h1E, 1'b0);
      run_op(8'h00, 8'h01, 1'b0, 8'hFF, 1'b1);
      run_op(8'h80, 8'h7F, 1'b1, 8'h00, 1'b0);
      run_op(8'h00, 8'hFF, 1'b1, 8'h00, 1'b1);

      // start held high, operands scrambled while running
      @(posedge clk);
      #1;
      A = 8'h10;
      B = 8'h01;
      Bin = 1'b0;
      start = 1'b1;
      @(posedge clk);
      #1;
      n = 1;
      while (!done && n < 40) begin
         A = 8'($urandom);
         B = 8'($urandom);
         Bin = 1'($urandom);
         @(posedge clk);
         #1;
         n++;
      end
      chk("held_latency", 32'(n), 32'(W + 1));
      chk("held_diff", 32'(Diff), 32'h0F);
      A = 8'h33;
      B = 8'h11;
      Bin = 1'b0;
      @(posedge clk);
      #1;
      chk("held_idle", 32'(busy), 32'd0);
      @(posedge clk);
      #1;
      start = 1'b0;
      chk("b2b_accept", 32'(busy), 32'd1);
      wait_done(n);
      chk("b2b_latency", 32'(n), 32'(W + 1));
      chk("b2b_diff", 32'(Diff), 32'h22);

      // abort in the 4th RUN cycle
      @(posedge clk);
      #1;
      A = 8'h77;
      B = 8'h11;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_done", 32'(done), 32'd0);
      chk("abort_diff", 32'(Diff), 32'd0);
      chk("abort_bout", 32'(Bout), 32'd0);
      #1;
      rst_n = 1'b1;
      dn = 0;
      repeat (20) begin
         @(posedge clk);
         #1;
         if (done) dn++;
      end
      chk("abort_no_done", 32'(dn), 32'd0);

      for (int i = 0; i < NOPS; i++) begin
         A = 8'($urandom);
         B = 8'($urandom);
         Bin = 1'($urandom);
         start = 1'b1;
         k = 0;
         do begin
            @(posedge clk);
            #1;
            k++;
         end while (!busy && k < 4);
         chk("rand_accept", 32'(busy), 32'd1);
         start = 1'b0;
         k = 0;
         while (busy && k < 20) begin
            start = 1'($urandom_range(0, 1));
            A = 8'($urandom);
            B = 8'($urandom);
            Bin = 1'($urandom);
            @(posedge clk);
            #1;
            k++;
         end
         start = 1'b0;
         chk("rand_complete", 32'(busy), 32'd0);
         repeat ($urandom_range(0, 2)) begin
            @(posedge clk);
            #1;
         end
      end

      repeat (3) @(posedge clk);
      #1;
      chk("done_count", 32'(dut_dn), 32'(m_dn));
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
